// File: rtl/chroma_threshold_calibrator_pkg.sv
// Shared types and helpers for the chroma threshold calibrator.
//   chroma_t      : 8-bit Cr/Cb sample
//   calState_t    : calibration controller states
//   thresholds_t  : the four active thresholds, packed together
//   satAdd/satSub : 8-bit saturating add / subtract via 9-bit intermediates
package chroma_threshold_calibrator_pkg;

    typedef logic [7:0] chroma_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        SAMPLE,
        APPLY
    } calState_t;

    typedef struct packed {
        chroma_t crLow;
        chroma_t crHigh;
        chroma_t cbLow;
        chroma_t cbHigh;
    } thresholds_t;

    // Channel lanes tracked in parallel
    localparam int NUM_CH = 2;
    localparam int CH_CR  = 0;
    localparam int CH_CB  = 1;

    function automatic chroma_t satAdd(input chroma_t a, input chroma_t b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic chroma_t satSub(input chroma_t a, input chroma_t b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        // Borrow out means the true result went negative
        return d[8] ? 8'h00 : d[7:0];
    endfunction

endpackage

// File: rtl/chroma_threshold_calibrator_minmax.sv
// Running min/max tracker for one chroma channel.
//   clk, reset : pixel clock, synchronous active-high reset
//   clear      : restart tracking (min=255, max=0)
//   enable     : fold value into min/max this cycle
//   value      : chroma sample
//   minVal/maxVal : running extremes since the last clear
module chroma_minmax_tracker
    import chroma_threshold_calibrator_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    clear,
    input  logic    enable,
    input  chroma_t value,
    output chroma_t minVal,
    output chroma_t maxVal
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            minVal <= 8'hFF;
            maxVal <= 8'h00;
        end else if (enable) begin
            if (value < minVal) minVal <= value;
            if (value > maxVal) maxVal <= value;
        end
    end

endmodule

// File: rtl/chroma_threshold_calibrator.sv
// Calibrates the red-pixel chroma thresholds used by the ball detector.
// A calibrate request waits for the next frame boundary, then samples Cr/Cb
// over a centred square window for FRAMES complete frames and applies
// min-margin / max+margin (saturated) as the new thresholds.
//   iVgaClk, reset      : pixel clock, synchronous active-high reset
//   iVgaVRequest        : active-lines flag; falling edge marks frame end
//   iVgaRequest         : valid pixel
//   iHIndex, iVIndex    : pixel coordinates
//   iCr, iCb            : pixel chroma, aligned with the indices
//   iCalibrate, iAbort  : start request / abandon calibration
//   iMargin             : margin latched at start
//   oCrLow..oCbHigh     : active thresholds
//   oBusy, oFreezeRam   : high whenever not IDLE
//   oDone, oError       : one-cycle result pulses
module chroma_threshold_calibrator
    import chroma_threshold_calibrator_pkg::*;
#(
    parameter int CENTER_H    = 320,
    parameter int CENTER_V    = 240,
    parameter int WIN_HALF    = 8,
    parameter int FRAMES      = 4,
    parameter int DEF_CR_LOW  = 150,
    parameter int DEF_CR_HIGH = 255,
    parameter int DEF_CB_LOW  = 0,
    parameter int DEF_CB_HIGH = 120
) (
    input  logic        iVgaClk,
    input  logic        reset,
    input  logic        iVgaVRequest,
    input  logic        iVgaRequest,
    input  logic [15:0] iHIndex,
    input  logic [15:0] iVIndex,
    input  logic [7:0]  iCr,
    input  logic [7:0]  iCb,
    input  logic        iCalibrate,
    input  logic        iAbort,
    input  logic [7:0]  iMargin,
    output logic [7:0]  oCrLow,
    output logic [7:0]  oCrHigh,
    output logic [7:0]  oCbLow,
    output logic [7:0]  oCbHigh,
    output logic        oBusy,
    output logic        oFreezeRam,
    output logic        oDone,
    output logic        oError
);

    // Window bounds; a negative lower edge clamps to column/row 0
    localparam logic [15:0] H_LO = 16'((CENTER_H > WIN_HALF) ? CENTER_H - WIN_HALF : 0);
    localparam logic [15:0] H_HI = 16'(CENTER_H + WIN_HALF);
    localparam logic [15:0] V_LO = 16'((CENTER_V > WIN_HALF) ? CENTER_V - WIN_HALF : 0);
    localparam logic [15:0] V_HI = 16'(CENTER_V + WIN_HALF);

    localparam thresholds_t DEF_THR = '{
        crLow:  8'(DEF_CR_LOW),
        crHigh: 8'(DEF_CR_HIGH),
        cbLow:  8'(DEF_CB_LOW),
        cbHigh: 8'(DEF_CB_HIGH)
    };

    calState_t   state, stateNext;
    thresholds_t thr;
    chroma_t     margin;
    logic [3:0]  frameCnt;
    logic        seen;
    logic        vReqQ;
    logic        vFall;
    logic        inWindow;
    logic        sampleEn;
    logic        start;
    logic        lastFrame;

    logic [NUM_CH-1:0][7:0] chanVal;
    logic [NUM_CH-1:0][7:0] chanMin;
    logic [NUM_CH-1:0][7:0] chanMax;

    assign vFall     = vReqQ & ~iVgaVRequest;
    assign inWindow  = (iHIndex >= H_LO) && (iHIndex <= H_HI) &&
                       (iVIndex >= V_LO) && (iVIndex <= V_HI);
    assign sampleEn  = (state == SAMPLE) && iVgaRequest && inWindow;
    assign start     = (state == IDLE) && iCalibrate;
    assign lastFrame = vFall && (frameCnt == 4'(FRAMES - 1));

    assign chanVal[CH_CR] = iCr;
    assign chanVal[CH_CB] = iCb;

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        chroma_minmax_tracker uTrk (
            .clk    (iVgaClk),
            .reset  (reset),
            .clear  (start),
            .enable (sampleEn),
            .value  (chanVal[c]),
            .minVal (chanMin[c]),
            .maxVal (chanMax[c])
        );
    end

    // Abort wins over the frame edge and over entering APPLY
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (iCalibrate) stateNext = WAIT_FRAME;
            WAIT_FRAME: if (iAbort) stateNext = IDLE;
                        else if (vFall) stateNext = SAMPLE;
            SAMPLE:     if (iAbort) stateNext = IDLE;
                        else if (lastFrame) stateNext = APPLY;
            APPLY:      stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iVgaClk) begin
        if (reset) begin
            state    <= IDLE;
            thr      <= DEF_THR;
            margin   <= 8'h00;
            frameCnt <= 4'd0;
            seen     <= 1'b0;
            vReqQ    <= 1'b0;
            oDone    <= 1'b0;
            oError   <= 1'b0;
        end else begin
            state <= stateNext;
            vReqQ <= iVgaVRequest;
            oDone  <= 1'b0;
            oError <= 1'b0;
            if (start) begin
                margin   <= iMargin;
                frameCnt <= 4'd0;
                seen     <= 1'b0;
            end
            if (state == SAMPLE) begin
                if (sampleEn) seen <= 1'b1;
                if (vFall) frameCnt <= frameCnt + 4'd1;
            end
            if (state == APPLY) begin
                if (seen) begin
                    thr.crLow  <= satSub(chanMin[CH_CR], margin);
                    thr.crHigh <= satAdd(chanMax[CH_CR], margin);
                    thr.cbLow  <= satSub(chanMin[CH_CB], margin);
                    thr.cbHigh <= satAdd(chanMax[CH_CB], margin);
                    oDone      <= 1'b1;
                end else begin
                    oError <= 1'b1;
                end
            end
        end
    end

    assign oCrLow     = thr.crLow;
    assign oCrHigh    = thr.crHigh;
    assign oCbLow     = thr.cbLow;
    assign oCbHigh    = thr.cbHigh;
    assign oBusy      = (state != IDLE);
    assign oFreezeRam = oBusy;

endmodule

// File: tb/tb_chroma_threshold_calibrator.sv
module tb_chroma_threshold_calibrator;

    logic        iVgaClk = 1'b0;
    logic        reset;
    logic        iVgaVRequest, iVgaRequest;
    logic [15:0] iHIndex, iVIndex;
    logic [7:0]  iCr, iCb, iMargin;
    logic        iCalibrate, iAbort;
    logic [7:0]  oCrLow, oCrHigh, oCbLow, oCbHigh;
    logic        oBusy, oFreezeRam, oDone, oError;

    chroma_threshold_calibrator dut (
        .iVgaClk(iVgaClk), .reset(reset),
        .iVgaVRequest(iVgaVRequest), .iVgaRequest(iVgaRequest),
        .iHIndex(iHIndex), .iVIndex(iVIndex), .iCr(iCr), .iCb(iCb),
        .iCalibrate(iCalibrate), .iAbort(iAbort), .iMargin(iMargin),
        .oCrLow(oCrLow), .oCrHigh(oCrHigh), .oCbLow(oCbLow), .oCbHigh(oCbHigh),
        .oBusy(oBusy), .oFreezeRam(oFreezeRam), .oDone(oDone), .oError(oError)
    );

    always #5 iVgaClk = ~iVgaClk;

    typedef struct {
        bit       isErr;
        bit [7:0] crLow, crHigh, cbLow, cbHigh;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastVfallCyc = 0;
    int lastPulseCyc = -1;
    bit [7:0] curCrLow = 150, curCrHigh = 255, curCbLow = 0, curCbHigh = 120;

    always @(posedge iVgaClk) cyc <= cyc + 1;

    // Result monitor: every oDone/oError pulse must match the oldest expectation
    always @(negedge iVgaClk) begin
        if (!reset && (oDone || oError)) begin
            sbEntry_t e;
            lastPulseCyc = cyc;
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: oDone=%0b oError=%0b with nothing expected", oDone, oError);
            end else begin
                e = sbQ.pop_front();
                if (oDone !== !e.isErr || oError !== e.isErr ||
                    oCrLow !== e.crLow || oCrHigh !== e.crHigh ||
                    oCbLow !== e.cbLow || oCbHigh !== e.cbHigh) begin
                    errors++;
                    $display("FAIL result: got done=%0b err=%0b thr=%0d/%0d/%0d/%0d, want done=%0b err=%0b thr=%0d/%0d/%0d/%0d",
                             oDone, oError, oCrLow, oCrHigh, oCbLow, oCbHigh,
                             !e.isErr, e.isErr, e.crLow, e.crHigh, e.cbLow, e.cbHigh);
                end
            end
        end
    end

    // Window is 320+-8 by 240+-8; the driven frame spans two pixels beyond each edge
    function automatic bit inWin(input int h, input int v);
        return (h >= 312) && (h <= 328) && (v >= 232) && (v <= 248);
    endfunction

    // mode 0/3: uniform 180/90; mode 1: Cr corners 5 and 250 else 128, Cb 100;
    // mode 2: decoy values 250/10. Outside the window always Cr=0, Cb=255.
    function automatic bit [15:0] pixVal(input int mode, input int h, input int v);
        if (!inWin(h, v)) return {8'd0, 8'd255};
        case (mode)
            1: begin
                if (h == 312 && v == 232) return {8'd5, 8'd100};
                if (h == 328 && v == 248) return {8'd250, 8'd100};
                return {8'd128, 8'd100};
            end
            2: return {8'd250, 8'd10};
            default: return {8'd180, 8'd90};
        endcase
    endfunction

    // One frame of 21x21 pixels then 4 blanking cycles; optional single-cycle
    // calibrate / abort / reset at a given pixel index (-1 = none).
    task automatic frame(input int mode, input int calAt, input int abortAt, input int resetAt);
        int idx = 0;
        bit [15:0] pv;
        for (int v = 230; v <= 250; v++) begin
            for (int h = 310; h <= 330; h++) begin
                pv = pixVal(mode, h, v);
                iVgaVRequest = 1'b1;
                iVgaRequest  = (mode != 3);
                iHIndex = 16'(h);
                iVIndex = 16'(v);
                iCr = pv[15:8];
                iCb = pv[7:0];
                iCalibrate = (idx == calAt);
                iAbort     = (idx == abortAt);
                reset      = (idx == resetAt);
                @(posedge iVgaClk); #1;
                if (idx == abortAt) begin
                    checks++;
                    if (oBusy !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_busy: oBusy=%0b want 0", oBusy);
                    end
                end
                if (idx == resetAt) begin
                    checks++;
                    if (oBusy !== 1'b0 || oFreezeRam !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_busy: oBusy=%0b oFreezeRam=%0b want 0/0", oBusy, oFreezeRam);
                    end
                end
                idx++;
            end
        end
        iCalibrate = 1'b0; iAbort = 1'b0; reset = 1'b0;
        iVgaVRequest = 1'b0; iVgaRequest = 1'b0;
        iCr = 8'd0; iCb = 8'd0;
        lastVfallCyc = cyc;
        repeat (4) begin @(posedge iVgaClk); #1; end
    endtask

    task automatic pushDone(input bit [7:0] crL, input bit [7:0] crH, input bit [7:0] cbL, input bit [7:0] cbH);
        sbEntry_t e;
        e.isErr = 1'b0; e.crLow = crL; e.crHigh = crH; e.cbLow = cbL; e.cbHigh = cbH;
        sbQ.push_back(e);
        curCrLow = crL; curCrHigh = crH; curCbLow = cbL; curCbHigh = cbH;
    endtask

    task automatic test_reset;
        checks++;
        if (oCrLow !== 8'd150 || oCrHigh !== 8'd255 || oCbLow !== 8'd0 || oCbHigh !== 8'd120 ||
            oBusy !== 1'b0 || oFreezeRam !== 1'b0 || oDone !== 1'b0 || oError !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: thr=%0d/%0d/%0d/%0d busy=%0b frz=%0b done=%0b err=%0b want 150/255/0/120 0 0 0 0",
                     oCrLow, oCrHigh, oCbLow, oCbHigh, oBusy, oFreezeRam, oDone, oError);
        end
    endtask

    task automatic test_uniform;
        iMargin = 8'd10;
        pushDone(8'd170, 8'd190, 8'd80, 8'd100);
        // Calibrate mid-frame; decoy window pixels after the request must be ignored
        frame(2, 100, -1, -1);
        checks++;
        if (oBusy !== 1'b1 || oFreezeRam !== 1'b1) begin
            errors++;
            $display("FAIL uniform_busy: oBusy=%0b oFreezeRam=%0b want 1/1", oBusy, oFreezeRam);
        end
        repeat (4) frame(0, -1, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0 || lastPulseCyc != lastVfallCyc + 2) begin
            errors++;
            $display("FAIL uniform_latency: pulse at cycle %0d want %0d (pending %0d)",
                     lastPulseCyc, lastVfallCyc + 2, sbQ.size());
        end
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL uniform_idle: oBusy=%0b want 0", oBusy);
        end
    endtask

    task automatic test_saturation;
        iMargin = 8'd20;
        pushDone(8'd0, 8'd255, 8'd80, 8'd120);
        frame(1, 0, -1, -1);
        repeat (4) frame(1, -1, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL saturation_pending: %0d results outstanding want 0", sbQ.size());
        end
    endtask

    task automatic test_window_edges;
        // Zero margin exposes the extreme corners exactly
        iMargin = 8'd0;
        pushDone(8'd5, 8'd250, 8'd100, 8'd100);
        frame(1, 0, -1, -1);
        repeat (4) frame(1, -1, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0 || lastPulseCyc != lastVfallCyc + 2) begin
            errors++;
            $display("FAIL edges_latency: pulse at cycle %0d want %0d (pending %0d)",
                     lastPulseCyc, lastVfallCyc + 2, sbQ.size());
        end
    endtask

    task automatic test_no_samples;
        sbEntry_t e;
        iMargin = 8'd7;
        e.isErr = 1'b1; e.crLow = curCrLow; e.crHigh = curCrHigh; e.cbLow = curCbLow; e.cbHigh = curCbHigh;
        sbQ.push_back(e);
        frame(3, 0, -1, -1);
        repeat (4) frame(3, -1, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0 || oCrLow !== curCrLow || oCrHigh !== curCrHigh ||
            oCbLow !== curCbLow || oCbHigh !== curCbHigh) begin
            errors++;
            $display("FAIL no_samples: pending=%0d thr=%0d/%0d/%0d/%0d want 0 %0d/%0d/%0d/%0d",
                     sbQ.size(), oCrLow, oCrHigh, oCbLow, oCbHigh, curCrLow, curCrHigh, curCbLow, curCbHigh);
        end
    endtask

    task automatic test_abort;
        iMargin = 8'd3;
        frame(0, 0, -1, -1);
        frame(0, -1, -1, -1);
        frame(0, -1, 200, -1);
        frame(0, -1, -1, -1);
        checks++;
        if (oBusy !== 1'b0 || oCrLow !== curCrLow || oCrHigh !== curCrHigh ||
            oCbLow !== curCbLow || oCbHigh !== curCbHigh) begin
            errors++;
            $display("FAIL abort_thr: busy=%0b thr=%0d/%0d/%0d/%0d want 0 %0d/%0d/%0d/%0d",
                     oBusy, oCrLow, oCrHigh, oCbLow, oCbHigh, curCrLow, curCrHigh, curCbLow, curCbHigh);
        end
        iMargin = 8'd5;
        pushDone(8'd175, 8'd185, 8'd85, 8'd95);
        frame(0, 0, -1, -1);
        repeat (4) frame(0, -1, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL abort_recal: %0d results outstanding want 0", sbQ.size());
        end
    endtask

    task automatic test_busy_repeat;
        iMargin = 8'd0;
        pushDone(8'd180, 8'd180, 8'd90, 8'd90);
        frame(0, 0, -1, -1);
        // Repeated requests while sampling must not restart the count
        repeat (4) frame(0, 50, -1, -1);
        for (int k = 0; k < 20 && sbQ.size() != 0; k++) begin @(posedge iVgaClk); #1; end
        checks++;
        if (sbQ.size() != 0 || lastPulseCyc != lastVfallCyc + 2) begin
            errors++;
            $display("FAIL busy_repeat: pulse at cycle %0d want %0d (pending %0d)",
                     lastPulseCyc, lastVfallCyc + 2, sbQ.size());
        end
    endtask

    task automatic test_reset_mid;
        iMargin = 8'd4;
        frame(0, 0, -1, -1);
        frame(0, 30, -1, 150);
        curCrLow = 8'd150; curCrHigh = 8'd255; curCbLow = 8'd0; curCbHigh = 8'd120;
        checks++;
        if (oBusy !== 1'b0 || oFreezeRam !== 1'b0 || oCrLow !== 8'd150 || oCrHigh !== 8'd255 ||
            oCbLow !== 8'd0 || oCbHigh !== 8'd120) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b frz=%0b thr=%0d/%0d/%0d/%0d want 0 0 150/255/0/120",
                     oBusy, oFreezeRam, oCrLow, oCrHigh, oCbLow, oCbHigh);
        end
        // No stray result may follow a reset
        repeat (2) frame(0, -1, -1, -1);
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: oBusy=%0b want 0", oBusy);
        end
    endtask

    initial begin
        reset = 1'b1;
        iVgaVRequest = 1'b0; iVgaRequest = 1'b0;
        iHIndex = 16'd0; iVIndex = 16'd0; iCr = 8'd0; iCb = 8'd0;
        iCalibrate = 1'b0; iAbort = 1'b0; iMargin = 8'd0;
        repeat (3) @(posedge iVgaClk);
        #1 reset = 1'b0;
        @(posedge iVgaClk); #1;
        test_reset;
        test_uniform;
        test_saturation;
        test_window_edges;
        test_no_samples;
        test_abort;
        test_busy_repeat;
        test_reset_mid;
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
